// File: rtl/scale_pkg.sv
// Shared types and constants for the scale-parameter generator: FSM state
// encoding, unity scale helper and default clamp limits.
package scale_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_DIV_H,
        ST_DIV_V,
        ST_MUL,
        ST_COMMIT
    } state_e;

    localparam int DEF_FRAC  = 8;
    localparam int DEF_MAX_W = 3840;
    localparam int DEF_MAX_H = 2160;

    // Fixed-point 1.0 for a given number of fraction bits.
    function automatic int unsigned unity(input int unsigned frac);
        return 32'd1 << frac;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle. The first bit is produced in
// the start cycle, so a DVD_W-bit dividend completes in exactly DVD_W cycles.
module seq_divider #(
    parameter int DVD_W = 21,
    parameter int DVS_W = 13,
    parameter int Q_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, rem_d, rem_src;
    logic [DVD_W-1:0] quo_q, quo_d, quo_src;
    logic [DVS_W-1:0] dvs_q, dvs_cur;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic [DVS_W:0]   shifted;
    logic             q_bit;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        q_bit   = 1'b0;
        rem_src = start ? '0 : rem_q;
        quo_src = start ? dividend : quo_q;
        dvs_cur = start ? divisor : dvs_q;
        shifted = {rem_src, quo_src[DVD_W-1]};
        rem_d   = shifted[DVS_W-1:0];
        if (shifted >= {1'b0, dvs_cur}) begin
            q_bit = 1'b1;
            rem_d = DVS_W'(shifted - {1'b0, dvs_cur});
        end
        quo_d = {quo_src[DVD_W-2:0], q_bit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= divisor;
            cnt_q <= CNT_W'(DVD_W - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) run_q <= 1'b0;
        end
    end

    // done flags the cycle performing the last step; quotient is valid the cycle after.
    assign done = run_q && (cnt_q == CNT_W'(1));

    // A zero divisor only arises from a zero source dimension, so report 0.
    always_comb begin
        if (dvs_q == '0)
            quotient = '0;
        else if (64'(quo_q) > ((64'd1 << Q_W) - 64'd1))
            quotient = '1;
        else
            quotient = Q_W'(quo_q);
    end

endmodule

// File: rtl/scale_param_gen.sv
// Computes per-frame scaler factors and DDR burst length on each write vsync
// fall. Optional target clamp to MAX_W/MAX_H under macro SCALE_TARGET_CLAMP_EN.
module scale_param_gen
    import scale_pkg::*;
#(
    parameter int DIM_W       = 13,
    parameter int FRAC        = DEF_FRAC,
    parameter int K_W         = 16,
    parameter int BURST_SHIFT = 4,
    parameter int MAX_W       = DEF_MAX_W,
    parameter int MAX_H       = DEF_MAX_H
) (
    input  logic               clk_wr,
    input  logic               rst,
    input  logic               wr_vsync,
    input  logic [DIM_W-1:0]   s_width,
    input  logic [DIM_W-1:0]   s_height,
    input  logic [DIM_W-1:0]   t_width_req,
    input  logic [DIM_W-1:0]   t_height_req,
    output logic [DIM_W-1:0]   t_width_wr,
    output logic [DIM_W-1:0]   t_height_wr,
    output logic [K_W-1:0]     h_scale_k,
    output logic [K_W-1:0]     v_scale_k,
    output logic [2*DIM_W-1:0] wr_bust_total_len,
    output logic               busy,
    output logic               param_valid
);

    localparam int DVD_W = DIM_W + FRAC;
    localparam int LEN_W = 2 * DIM_W;
    localparam int AREA_W = 2 * DIM_W + 1;

    state_e           state_q;
    logic             vsync_q, pending_q, busy_q, param_valid_q, div_start_q;
    logic [DIM_W-1:0] sw_q, sh_q, tw_q, th_q, tw_d, th_d;
    logic [K_W-1:0]   hk_q;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DIM_W-1:0] t_width_q, t_height_q;
    logic [K_W-1:0]   h_k_q, v_k_q;
    logic [LEN_W-1:0] bust_len_q;
    logic [DVD_W-1:0] div_dvd;
    logic [DIM_W-1:0] div_dvs;
    logic             div_done;
    logic [K_W-1:0]   div_quo;
    logic [AREA_W-1:0] area;
    logic             fall;

    assign fall = vsync_q & ~wr_vsync;

    always_comb begin
        tw_d = (t_width_req  == '0) ? s_width  : t_width_req;
        th_d = (t_height_req == '0) ? s_height : t_height_req;
`ifdef SCALE_TARGET_CLAMP_EN
        if (32'(tw_d) > MAX_W) tw_d = DIM_W'(MAX_W);
        if (32'(th_d) > MAX_H) th_d = DIM_W'(MAX_H);
`endif
    end

    always_comb begin
        div_dvd = (state_q == ST_DIV_V) ? DVD_W'(sh_q) << FRAC : DVD_W'(sw_q) << FRAC;
        div_dvs = (state_q == ST_DIV_V) ? th_q : tw_q;
    end

    // Round-up division by the burst size: add (2^BURST_SHIFT - 1) then shift.
    always_comb begin
        area  = AREA_W'(tw_q) * AREA_W'(th_q) + AREA_W'((1 << BURST_SHIFT) - 1);
        len_d = LEN_W'(area >> BURST_SHIFT);
    end

    seq_divider #(
        .DVD_W (DVD_W),
        .DVS_W (DIM_W),
        .Q_W   (K_W)
    ) u_div (
        .clk      (clk_wr),
        .rst      (rst),
        .start    (div_start_q),
        .dividend (div_dvd),
        .divisor  (div_dvs),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            vsync_q       <= 1'b0;
            pending_q     <= 1'b0;
            busy_q        <= 1'b0;
            param_valid_q <= 1'b0;
            div_start_q   <= 1'b0;
            sw_q          <= '0;
            sh_q          <= '0;
            tw_q          <= '0;
            th_q          <= '0;
            hk_q          <= '0;
            len_q         <= '0;
            t_width_q     <= '0;
            t_height_q    <= '0;
            h_k_q         <= K_W'(unity(FRAC));
            v_k_q         <= K_W'(unity(FRAC));
            bust_len_q    <= '0;
        end else begin
            vsync_q       <= wr_vsync;
            param_valid_q <= 1'b0;
            div_start_q   <= 1'b0;
            if (fall && state_q != ST_IDLE && state_q != ST_COMMIT) pending_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q <= ST_LATCH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    sw_q        <= s_width;
                    sh_q        <= s_height;
                    tw_q        <= tw_d;
                    th_q        <= th_d;
                    div_start_q <= 1'b1;
                    state_q     <= ST_DIV_H;
                end
                ST_DIV_H: begin
                    if (div_done) begin
                        div_start_q <= 1'b1;
                        state_q     <= ST_DIV_V;
                    end
                end
                ST_DIV_V: begin
                    // The horizontal quotient is still on the divider output in the start cycle.
                    if (div_start_q) hk_q <= div_quo;
                    if (div_done) state_q <= ST_MUL;
                end
                ST_MUL: begin
                    len_q   <= len_d;
                    state_q <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    t_width_q     <= tw_q;
                    t_height_q    <= th_q;
                    h_k_q         <= hk_q;
                    v_k_q         <= div_quo;
                    bust_len_q    <= len_q;
                    param_valid_q <= 1'b1;
                    if (pending_q || fall) begin
                        pending_q <= 1'b0;
                        state_q   <= ST_LATCH;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign t_width_wr        = t_width_q;
    assign t_height_wr       = t_height_q;
    assign h_scale_k         = h_k_q;
    assign v_scale_k         = v_k_q;
    assign wr_bust_total_len = bust_len_q;
    assign busy              = busy_q;
    assign param_valid       = param_valid_q;

endmodule
